// File: rtl/temp_sampler_if.sv
// Sample bus from temp_sampler to the monitor / BCD display path.
interface temp_sampler_if;
    logic       sample_sign;
    logic [5:0] sample_temp;
    logic [3:0] sample_frac;
    logic       sample_valid;
    logic       sample_changed;

    // Producer side: temp_sampler drives the latched sample.
    modport master (
        output sample_sign,
        output sample_temp,
        output sample_frac,
        output sample_valid,
        output sample_changed
    );

    // Consumer side: monitor / display path reads the latched sample.
    modport slave (
        input sample_sign,
        input sample_temp,
        input sample_frac,
        input sample_valid,
        input sample_changed
    );
endinterface

// File: rtl/temp_sampler.sv
// Synchronizes and debounces the sign key and temperature switches, toggles
// the sign mode on each accepted press, clamps the fractional digit to 0-9,
// and latches a coherent {sign, temp, frac} sample on each tick.
module temp_sampler #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              key_n,
    input  logic [9:0]        sw,
    output logic              sign_live,
    temp_sampler_if.master    smp
);

    localparam int unsigned SW_W = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] FRAC_MAX = 4'd9;

    logic              key_meta;
    logic              key_sync;
    logic              key_db;
    logic [CNT_W-1:0]  key_cnt;
    logic              key_accept_c;

    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [SW_W-1:0]   sw_cand;
    logic [SW_W-1:0]   sw_stable;
    logic [CNT_W-1:0]  sw_cnt;

    logic [3:0]        frac_c;
    logic              changed_c;

    logic              sample_sign_q;
    logic [5:0]        sample_temp_q;
    logic [3:0]        sample_frac_q;
    logic              sample_valid_q;
    logic              sample_changed_q;

    // Two-flop synchronizers; key idles released (1), switches idle at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    // Key is accepted once it has disagreed with the debounced value long enough.
    assign key_accept_c = (key_sync != key_db) && (key_cnt == CNT_LAST);

    // Key debounce counter and debounced key; press (1->0) toggles sign mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db    <= 1'b1;
            key_cnt   <= '0;
            sign_live <= 1'b0;
        end else if (key_sync == key_db) begin
            key_cnt <= '0;
        end else if (key_accept_c) begin
            key_db  <= key_sync;
            key_cnt <= '0;
            if (!key_sync) begin
                sign_live <= ~sign_live;
            end
        end else begin
            key_cnt <= key_cnt + CNT_W'(1);
        end
    end

    // Whole-vector switch debounce: any movement restarts the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cand   <= '0;
            sw_stable <= '0;
            sw_cnt    <= '0;
        end else if (sw_sync != sw_cand) begin
            sw_cand <= sw_sync;
            sw_cnt  <= '0;
        end else if (sw_cand != sw_stable) begin
            if (sw_cnt == CNT_LAST) begin
                sw_stable <= sw_cand;
                sw_cnt    <= '0;
            end else begin
                sw_cnt <= sw_cnt + CNT_W'(1);
            end
        end else begin
            sw_cnt <= '0;
        end
    end

    // Clamp the fractional digit and detect a change against the held sample.
    always_comb begin
        frac_c    = FRAC_MAX;
        changed_c = 1'b0;
        if (sw_stable[3:0] <= FRAC_MAX) begin
            frac_c = sw_stable[3:0];
        end
        changed_c = (sign_live      != sample_sign_q) ||
                    (sw_stable[9:4] != sample_temp_q) ||
                    (frac_c         != sample_frac_q);
    end

    // Sample latch on tick; valid pulses the cycle after each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_sign_q    <= 1'b0;
            sample_temp_q    <= '0;
            sample_frac_q    <= '0;
            sample_valid_q   <= 1'b0;
            sample_changed_q <= 1'b0;
        end else begin
            sample_valid_q <= tick;
            if (tick) begin
                sample_sign_q    <= sign_live;
                sample_temp_q    <= sw_stable[9:4];
                sample_frac_q    <= frac_c;
                sample_changed_q <= changed_c;
            end
        end
    end

    assign smp.sample_sign    = sample_sign_q;
    assign smp.sample_temp    = sample_temp_q;
    assign smp.sample_frac    = sample_frac_q;
    assign smp.sample_valid   = sample_valid_q;
    assign smp.sample_changed = sample_changed_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Scoreboard bench for temp_sampler with DEBOUNCE_CYCLES=4.
module tb_temp_sampler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       key_n;
    logic [9:0] sw;
    logic       sign_live;

    temp_sampler_if bus ();

    temp_sampler #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_n    (key_n),
        .sw       (sw),
        .sign_live(sign_live),
        .smp      (bus)
    );

    // Expected sample packed as {sign, temp[5:0], frac[3:0], changed}.
    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Issue one single-cycle tick and record the hand-computed expected sample.
    task automatic do_tick(input logic s, input logic [5:0] t, input logic [3:0] f, input logic c);
        tick = 1'b1;
        exp_q.push_back({s, t, f, c});
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Monitor: compare each presented sample against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample %h with empty scoreboard",
                         {bus.sample_sign, bus.sample_temp, bus.sample_frac, bus.sample_changed});
            end else begin
                chk("sample", {bus.sample_sign, bus.sample_temp, bus.sample_frac, bus.sample_changed},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        rst   = 1'b1;
        tick  = 1'b0;
        key_n = 1'b1;
        sw    = 10'h000;

        // 1. Reset with tick pulsing: valid must stay low.
        for (int i = 0; i < 4; i++) begin
            tick = i[0];
            @(negedge clk);
            chk("valid_in_reset", 12'(bus.sample_valid), 12'h0);
        end
        tick = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        chk("rst_sign_live", 12'(sign_live), 12'h0);
        chk("rst_sample", {bus.sample_sign, bus.sample_temp, bus.sample_frac, bus.sample_changed}, 12'h0);
        chk("rst_valid", 12'(bus.sample_valid), 12'h0);

        // 2a. Three-cycle glitch is rejected.
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("glitch_sign", 12'(sign_live), 12'h0);
        end

        // 2b. Ten-cycle press: toggles on the 6th edge after key_n falls.
        key_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("press_sign", 12'(sign_live), (i >= 5) ? 12'h1 : 12'h0);
        end
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("release_sign", 12'(sign_live), 12'h1);
        end

        // 3. Switch capture 42.7.
        sw = 10'b101010_0111;
        repeat (8) @(negedge clk);
        do_tick(1'b1, 6'd42, 4'd7, 1'b1);
        @(negedge clk);

        // 4. Clamp: 3.12 reads as 3.9.
        sw = 10'b000011_1100;
        repeat (8) @(negedge clk);
        do_tick(1'b1, 6'd3, 4'd9, 1'b1);
        @(negedge clk);

        // 5. Bouncing switches keep the prior sample.
        for (int i = 0; i < 10; i++) begin
            sw = i[0] ? 10'h2AA : 10'h155;
            if (i[0]) begin
                do_tick(1'b1, 6'd3, 4'd9, 1'b0);
            end else begin
                @(negedge clk);
            end
            @(negedge clk);
        end
        sw = 10'h2AA;
        repeat (8) @(negedge clk);
        do_tick(1'b1, 6'd42, 4'd9, 1'b1);
        @(negedge clk);

        // 6a. Back-to-back ticks with unchanged inputs.
        tick = 1'b1;
        exp_q.push_back({1'b1, 6'd42, 4'd9, 1'b0});
        @(negedge clk);
        exp_q.push_back({1'b1, 6'd42, 4'd9, 1'b0});
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);

        // 6b. Tick on the same edge as a sign toggle sees the old sign.
        key_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_toggle_sign", 12'(sign_live), 12'h1);
        do_tick(1'b1, 6'd42, 4'd9, 1'b0);
        chk("post_toggle_sign", 12'(sign_live), 12'h0);
        do_tick(1'b0, 6'd42, 4'd9, 1'b1);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("final_sign", 12'(sign_live), 12'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending samples expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
